// File: rtl/pipe_ctrl_pkg.sv
// Shared types and trap cause codes for the pipeline hazard/trap sequencer.
// No logic; imported by the sequencer top and its memory-wait timer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2,
    RETURN   = 2'd3
  } state_t;

  localparam int CAUSE_ILLEGAL    = 2;
  localparam int CAUSE_LOAD_FAULT = 5;
  localparam int CAUSE_M_EXT_IRQ  = 11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM_WAIT cycles; the timeout flag is combinational on the count, with a 1-cycle update.
// No backpressure: start/en/clr are sampled every cycle, and the count saturates instead of wrapping.
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic en,
  output logic timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // The stall cycle spent in RUN counts as the first wait cycle, so start loads 1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = (cnt == CNT_LAST);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for stall, flush, PC redirect and the trap/mret strobes. A DE event at cycle N gives flush/redirect at N+1.
// Stall_MW holds Decode/Execute until dmem_ack. Flush and stall come from disjoint states, so they are never asserted together.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CAUSE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_op_DE,
  input  logic               illegal_DE,
  input  logic               mret_DE,
  input  logic               irq_pending,
  input  logic               dmem_ack,
  output logic               Stall_MW,
  output logic               csr_flush,
  output logic               dmem_req,
  output logic               pc_redirect,
  output logic               trap_valid,
  output logic               mret_valid,
  output logic [CAUSE_W-1:0] trap_cause
);

  state_t               state, state_nxt;
  logic [CAUSE_W-1:0]   cause_q, cause_nxt;
  logic                 tmr_start, tmr_en, tmr_clr, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cause_q <= '0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cause_nxt   = cause_q;
    Stall_MW    = 1'b0;
    csr_flush   = 1'b0;
    dmem_req    = 1'b0;
    pc_redirect = 1'b0;
    trap_valid  = 1'b0;
    mret_valid  = 1'b0;
    tmr_start   = 1'b0;
    tmr_en      = 1'b0;
    case (state)
      RUN: begin
        if (illegal_DE) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_W'(CAUSE_ILLEGAL);
        end else if (mret_DE) begin
          state_nxt = RETURN;
        end else if (irq_pending) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_W'(CAUSE_M_EXT_IRQ);
        end else if (mem_op_DE) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            Stall_MW  = 1'b1;
            state_nxt = MEM_WAIT;
            tmr_start = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        // Interrupts wait for the access to finish; the level-held request is taken from RUN.
        dmem_req = 1'b1;
        Stall_MW = ~dmem_ack;
        if (dmem_ack) begin
          state_nxt = RUN;
        end else if (timeout) begin
          state_nxt = TRAP;
          cause_nxt = CAUSE_W'(CAUSE_LOAD_FAULT);
        end else begin
          tmr_en = 1'b1;
        end
      end
      TRAP: begin
        csr_flush   = 1'b1;
        pc_redirect = 1'b1;
        trap_valid  = 1'b1;
        state_nxt   = RUN;
      end
      RETURN: begin
        csr_flush   = 1'b1;
        pc_redirect = 1'b1;
        mret_valid  = 1'b1;
        state_nxt   = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign tmr_clr    = ~(tmr_start | tmr_en);
  assign trap_cause = cause_q;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .start  (tmr_start),
    .en     (tmr_en),
    .timeout(timeout)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 3-stage RISC-V pipeline.
- Generates Stall_MW, which holds the Decode/Execute pipeline register.
- Generates csr_flush, which clears the Fetch/Decode and Decode/Execute registers.
- Drives the PC redirect and the trap handshake to the CSR unit.
- Sits beside the datapath and observes decode/execute-stage status, the data-memory handshake and the interrupt line.
- Owns the multi-cycle memory-wait and trap-entry/return sequencing.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT without dmem_ack before a bus-error trap is raised (must be >= 2).
CAUSE_W, 4, width of trap_cause.

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
mem_op_DE  in  1  load or store present in DE stage
illegal_DE  in  1  illegal instruction decoded in DE stage
mret_DE  in  1  MRET in DE stage
irq_pending  in  1  level interrupt request from CSR unit, already masked by mstatus.MIE/mie
dmem_ack  in  1  data memory completes current access this cycle
Stall_MW  out  1  hold Decode/Execute register
csr_flush  out  1  flush pipeline registers
dmem_req  out  1  data memory request, held until ack
pc_redirect  out  1  fetch PC := CSR-supplied target (mtvec or mepc) this cycle
trap_valid  out  1  one-cycle strobe: CSR unit saves mepc/mcause
mret_valid  out  1  one-cycle strobe: CSR unit restores mstatus
trap_cause  out  CAUSE_W  cause code, valid with trap_valid

Behaviour:
- States: RUN, MEM_WAIT, TRAP, RETURN. Reset -> RUN; timeout counter = 0; all outputs 0.
- Event priority in RUN: illegal_DE > mret_DE > irq_pending > mem_op_DE.
- RUN, illegal_DE=1:
  - Next state TRAP; trap_cause register := 2.
- RUN, mret_DE=1:
  - Next state RETURN.
- RUN, irq_pending=1 (no higher-priority event):
  - Next state TRAP; trap_cause := 11 (machine external interrupt).
- RUN, mem_op_DE=1:
  - dmem_req=1 combinationally.
  - dmem_ack=1 the same cycle: zero-wait access; no stall, stay in RUN.
  - Otherwise: Stall_MW=1 this cycle; next state MEM_WAIT; counter := 1.
- MEM_WAIT:
  - dmem_req=1.
  - Stall_MW = ~dmem_ack, so the register advances in the ack cycle.
  - On ack: next state RUN; counter := 0.
  - No ack: counter increments. When counter == MEM_TIMEOUT-1 and no ack: next state TRAP; trap_cause := 5 (access fault); dmem_req drops the following cycle.
  - irq_pending is ignored in MEM_WAIT. An interrupt arriving mid-access is taken from RUN after the access completes (level-held, never lost).
- TRAP, exactly one cycle:
  - csr_flush=1, pc_redirect=1, trap_valid=1; trap_cause driven from its register; Stall_MW=0.
  - Next state RUN. trap_cause holds its value until the next trap.
- RETURN, exactly one cycle:
  - csr_flush=1, pc_redirect=1, mret_valid=1.
  - Next state RUN.
- csr_flush and Stall_MW are never both 1. Flush wins; enforced by the state encoding.
- Latency:
  - Trap/return event seen in DE at cycle N -> flush/redirect at N+1 -> first handler fetch at N+2.
  - Back-to-back events: RUN is re-entered for at least one cycle between traps. An event still present after the flush is a new event.
- Reset mid-operation: any state -> RUN next edge; dmem_req drops immediately in the reset cycle's following state; counter cleared.
- Counter width: $clog2(MEM_TIMEOUT+1); saturates, never wraps.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, TRAP, RETURN)
  - cause constants CAUSE_ILLEGAL=2, CAUSE_LOAD_FAULT=5, CAUSE_M_EXT_IRQ=11
- One natural sub-module: mem_wait_timer (counter, clear/enable, timeout flag).
- FSM and output decode stay in the top module.

Test Plan:
- Reset hold then release with all inputs 0 -> every output 0 for 5 cycles; asserting rst in MEM_WAIT returns to RUN with Stall_MW=0, dmem_req=0 next cycle.
- mem_op_DE=1 at cycle 10, dmem_ack at cycle 13:
  - Stall_MW=1 cycles 10–12, 0 at cycle 13.
  - dmem_req=1 cycles 10–13.
  - Zero-wait variant (ack at cycle 10) -> no stall.
- mem_op_DE=1, no ack, MEM_TIMEOUT=16:
  - Stall_MW high 16 cycles.
  - TRAP cycle: csr_flush=1, pc_redirect=1, trap_valid=1, trap_cause=5.
  - Next cycle: dmem_req=0.
- irq_pending raised during MEM_WAIT, ack 3 cycles later -> no flush before ack; trap_valid with cause 11 exactly 2 cycles after ack cycle.
- illegal_DE and irq_pending asserted in the same RUN cycle -> one TRAP cycle with trap_cause=2; after one RUN cycle, a second TRAP with cause 11 if irq still pending.
- mret_DE=1 -> next cycle csr_flush=1, pc_redirect=1, mret_valid=1, trap_valid=0; then RUN.
